// File: rtl/aes_inv_core.sv
// rtl/aes_inv_core.sv - iterative AES-128 decryption core, one round per clock
// Forward-expands the key to k10, then unrolls the key schedule backwards alongside the inverse cipher.

module aes_inv_core_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    logic [10:0] base;
    assign base     = 11'd2047 - {in_byte, 3'b000};
    assign out_byte = TABLE[base -: 8];
endmodule

module aes_inv_core_inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [2047:0] TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };
    logic [10:0] base;
    assign base     = 11'd2047 - {in_byte, 3'b000};
    assign out_byte = TABLE[base -: 8];
endmodule

module aes_inv_core (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iStDec,
    output logic         oDecDone,
    output logic         oBusy,
    input  logic [127:0] iAesKey,
    input  logic [127:0] iCpText,
    output logic [127:0] oPlainText
);
    typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_INIT, S_ROUND, S_LAST, S_DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] pt_q, pt_d;
    logic         done_q, done_d;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xt(a[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // State bytes are column-major: byte 4c+r holds s(r,c); row r rotates right by r.
    logic [127:0] shifted, sub_out, add_key, mixed;
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(4*c+r) -: 8] = state_q[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
        aes_inv_core_inv_sbox u_inv_sbox (
            .in_byte  (shifted[127-8*g -: 8]),
            .out_byte (sub_out[127-8*g -: 8])
        );
    end

    assign add_key = sub_out ^ key_q;
    assign mixed   = {inv_mix_col(add_key[127:96]), inv_mix_col(add_key[95:64]),
                      inv_mix_col(add_key[63:32]),  inv_mix_col(add_key[31:0])};

    // One SubWord serves both directions: forward uses w3, backward uses the recovered w3'.
    logic [31:0] w0, w1, w2, w3, w3_inv, sub_in, rot_word, sub_word, t_word;
    logic [3:0]  rcon_idx;
    logic [127:0] key_fwd, key_inv;

    assign w0       = key_q[127:96];
    assign w1       = key_q[95:64];
    assign w2       = key_q[63:32];
    assign w3       = key_q[31:0];
    assign w3_inv   = w3 ^ w2;
    assign sub_in   = (fsm_q == S_KEYEXP) ? w3 : w3_inv;
    assign rot_word = {sub_in[23:0], sub_in[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_inv_core_sbox u_sbox (
            .in_byte  (rot_word[31-8*g -: 8]),
            .out_byte (sub_word[31-8*g -: 8])
        );
    end

    assign rcon_idx = (fsm_q == S_INIT) ? 4'd10 : cnt_q;
    assign t_word   = sub_word ^ {rcon(rcon_idx), 24'h000000};

    always_comb begin
        logic [31:0] e0, e1, e2;
        e0      = w0 ^ t_word;
        e1      = w1 ^ e0;
        e2      = w2 ^ e1;
        key_fwd = {e0, e1, e2, w3 ^ e2};
        key_inv = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, w3_inv};
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (iStDec) begin
                    state_d = iCpText;
                    key_d   = iAesKey;
                    cnt_d   = 4'd1;
                    fsm_d   = S_KEYEXP;
                end
            end
            S_KEYEXP: begin
                key_d = key_fwd;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd10) fsm_d = S_INIT;
            end
            S_INIT: begin
                state_d = state_q ^ key_q;
                key_d   = key_inv;
                cnt_d   = 4'd9;
                fsm_d   = S_ROUND;
            end
            S_ROUND: begin
                state_d = mixed;
                key_d   = key_inv;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) fsm_d = S_LAST;
            end
            S_LAST: begin
                pt_d  = add_key;
                fsm_d = S_DONE;
            end
            S_DONE: begin
                done_d = 1'b1;
                fsm_d  = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
            pt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
        end
    end

    assign oDecDone   = done_q;
    assign oBusy      = (fsm_q != S_IDLE);
    assign oPlainText = pt_q;
endmodule

// File: tb/tb_aes_inv_core.sv
// tb/tb_aes_inv_core.sv - self-checking bench for aes_inv_core
// Directed FIPS-197 vectors plus random round trips through a behavioural AES encryptor.

module tb_aes_inv_core;
    logic         iClk = 1'b0;
    logic         iRst;
    logic         iStDec;
    logic         oDecDone;
    logic         oBusy;
    logic [127:0] iAesKey;
    logic [127:0] iCpText;
    logic [127:0] oPlainText;

    aes_inv_core dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iStDec     (iStDec),
        .oDecDone   (oDecDone),
        .oBusy      (oBusy),
        .iAesKey    (iAesKey),
        .iCpText    (iCpText),
        .oPlainText (oPlainText)
    );

    always #5 iClk = ~iClk;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    int errors = 0;
    int checks = 0;
    logic [7:0]   sbox_tab [256];
    logic [127:0] last_pt_pre;
    logic [127:0] last_key_init;
    int           last_busy;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_x2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = gf_x2(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  rc = 8'h01;
        logic [31:0] tmp;
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]], sbox_tab[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = gf_x2(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = sbox_tab[s[4*((c+r)%4)+r]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[4*c+0] = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called between edges; the start is sampled at the next rising edge (E0).
    task automatic do_start(input logic [127:0] key, input logic [127:0] ct);
        iStDec  = 1'b1;
        iAesKey = key;
        iCpText = ct;
        @(posedge iClk);
        #1;
        iStDec  = 1'b0;
        iAesKey = rand128();
        iCpText = rand128();
    endtask

    // Returns at the falling edge where oDecDone is seen; pa/pb re-pulse start at those cycles.
    task automatic wait_done(input string tag, input int pa, input int pb, output int lat);
        bit found = 1'b0;
        lat = 0;
        last_busy = 0;
        while (!found && lat < 40) begin
            @(posedge iClk);
            lat++;
            @(negedge iClk);
            if (lat == 10) last_key_init = dut.key_q;
            if (lat == 20) last_pt_pre = oPlainText;
            if (oBusy) last_busy++;
            if (oDecDone) found = 1'b1;
            iStDec = (lat == pa || lat == pb);
            if (iStDec) begin
                iAesKey = rand128();
                iCpText = rand128();
            end
        end
        iStDec = 1'b0;
        check({tag, " done_seen"}, 128'(found), 128'd1);
    endtask

    task automatic run(input string tag, input logic [127:0] key, input logic [127:0] ct,
                       input logic [127:0] exp, input int pa, input int pb, input bit full);
        int lat;
        do_start(key, ct);
        wait_done(tag, pa, pb, lat);
        check({tag, " latency"}, 128'(lat), 128'd22);
        check({tag, " plaintext"}, oPlainText, exp);
        if (full) begin
            check({tag, " busy_cycles"}, 128'(last_busy), 128'd21);
            @(negedge iClk);
            check({tag, " done_width"}, 128'(oDecDone), 128'd0);
        end
    endtask

    initial begin
        int ndone;
        logic [127:0] k, p;
        iRst    = 1'b1;
        iStDec  = 1'b0;
        iAesKey = '0;
        iCpText = '0;
        build_sbox();
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        check("reset done", 128'(oDecDone), 128'd0);
        check("reset busy", 128'(oBusy), 128'd0);
        check("reset pt", oPlainText, 128'd0);
        iRst = 1'b0;
        @(negedge iClk);

        run("c1", C1_KEY, C1_CT, C1_PT, -1, -1, 1'b1);
        run("appb", B_KEY, B_CT, B_PT, -1, -1, 1'b1);
        check("appb k10", last_key_init, B_K10);

        run("b2b first", C1_KEY, C1_CT, C1_PT, -1, -1, 1'b0);
        run("b2b second", B_KEY, B_CT, B_PT, -1, -1, 1'b0);
        check("b2b hold", last_pt_pre, C1_PT);
        @(negedge iClk);

        run("ignored", C1_KEY, C1_CT, C1_PT, 5, 15, 1'b1);

        do_start(B_KEY, B_CT);
        repeat (12) @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        check("midrst busy", 128'(oBusy), 128'd0);
        check("midrst pt", oPlainText, 128'd0);
        check("midrst done", 128'(oDecDone), 128'd0);
        ndone = 0;
        repeat (30) begin
            @(negedge iClk);
            if (oDecDone) ndone++;
        end
        check("midrst no_done", 128'(ndone), 128'd0);

        iRst   = 1'b1;
        iStDec = 1'b1;
        @(negedge iClk);
        iRst   = 1'b0;
        iStDec = 1'b0;
        check("rst_vs_start busy", 128'(oBusy), 128'd0);
        @(negedge iClk);
        check("rst_vs_start idle", 128'(oBusy), 128'd0);

        run("fresh c1", C1_KEY, C1_CT, C1_PT, -1, -1, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            k = rand128();
            p = rand128();
            run("roundtrip", k, aes_enc(k, p), p, -1, -1, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge iClk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
